satd_diff_stage: RTL
====================

Name: satd_diff_stage

Overview:
- Parametrised residual stage at the head of the SATD datapath.
- Takes one row of LANES original and LANES current samples per beat and produces per-lane ORG-CUR residuals for the Hadamard stage.
- Generalises the fixed 8-lane, 8-bit, always-accept difference register:
  - parametrised lane count and bit depth;
  - valid/ready handshake with a 2-entry skid buffer;
  - per-block row counter with first/last tags;
  - selectable signed or absolute mode, latched per block.

Parameters:
- BIT_DEPTH, 8, sample width in bits (8..12).
- LANES, 8, samples per row (4, 8 or 16).
- ROWS, 8, rows per block (power of two, 4..32); sets the row counter wrap.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- org  in  LANES*BIT_DEPTH  original samples; lane i at [i*BIT_DEPTH +: BIT_DEPTH], unsigned.
- cur  in  LANES*BIT_DEPTH  current/predicted samples, same layout.
- abs_mode  in  1  0 = signed residual, 1 = absolute residual; sampled on the first row of each block only.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- diff  out  LANES*(BIT_DEPTH+1)  residuals; lane i at [i*(BIT_DEPTH+1) +: BIT_DEPTH+1].
- out_row  out  $clog2(ROWS)  row index of the beat within its block.
- out_first  out  1  beat is row 0 of the block.
- out_last  out  1  beat is row ROWS-1 of the block.

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset RST is synchronous and active-high; all state changes only on posedge CLK.
- Reset values:
  - out_valid=0, diff=0, out_row=0, out_first=0, out_last=0.
  - Row counter=0, latched mode=0, skid buffer empty.
  - in_ready=0 while RST is high; in_ready=1 from the first cycle after RST deasserts.
- Handshakes:
  - Input accepted on a cycle with in_valid && in_ready.
  - Output transferred on a cycle with out_valid && out_ready.
  - out_valid, diff and tags hold stable until transferred.
- Latency: 1 cycle. A beat accepted at edge N is presented at out_valid after edge N when the output register is empty or draining that cycle.
- Buffering: 2 entries, main output register plus skid register.
  - in_ready = !skid_full, registered; no combinational path from out_ready to in_ready.
  - Accept while the main register is held (out_ready=0) writes the skid register and drops in_ready next cycle.
  - On drain, skid moves to main and in_ready rises next cycle.
  - Simultaneous accept and drain with the skid empty: main takes the new beat and the skid stays empty.
  - Beat order is always preserved; no drop, no duplicate.
- Arithmetic, computed at accept time and stored with the beat:
  - Signed mode: diff_i = zero-extended org_i minus zero-extended cur_i, BIT_DEPTH+1 bit two's complement. Never overflows.
  - Abs mode: diff_i = |org_i - cur_i|, unsigned, MSB always 0.
- Row counter and mode:
  - Increments on every accept; wraps ROWS-1 -> 0.
  - Each beat's tags are taken from the counter value at its accept: out_row=counter, out_first=(counter==0), out_last=(counter==ROWS-1).
  - abs_mode is latched only on an accept with counter==0. Changes mid-block are ignored until the next block.
- Reset mid-operation: buffered beats are discarded, the counter returns to 0, no out_valid the cycle after reset.
- Idle: with in_valid=0, state holds; the counter does not advance.

Decomposition:
- Package satd_pkg:
  - localparam DEFAULT_BIT_DEPTH=8.
  - Function diff_w(bd) returns bd+1.
  - Typedef satd_mode_t enum {SATD_SIGNED, SATD_ABS}.
  - Struct template satd_tag_t {row, first, last}, shared with the downstream Hadamard stage.
- Sub-module satd_skid_buf: generic 2-entry valid/ready buffer parametrised on payload width (diff + tags). The top does the arithmetic, row counter and mode latch.

Test Plan:
- Reset then one beat, LANES=8, BIT_DEPTH=8, signed mode, org all 200, cur all 55, out_ready=1 -> next cycle out_valid=1, every lane diff=9'h091 (+145), out_row=0, out_first=1.
- Signed extremes: org=0/cur=255 and org=255/cur=0 in alternate lanes -> lanes read 9'h101 (-255) and 9'h0FF (+255).
- Abs mode:
  - Block starts with abs_mode=1, org=10, cur=250 -> diff=240 for all 8 rows.
  - abs_mode toggled to 0 at row 3 -> rows 3..7 still abs.
  - Next block honours abs_mode=0 -> diff=9'h110 (-240).
- Backpressure: stream 8 rows with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts. After release, rows 0..7 emerge in order, out_last=1 only on row 7, then out_row wraps to 0 on the 9th beat.
- Continuous streaming with in_valid=1 and out_ready=1 for 64 cycles -> one beat per cycle, in_ready never drops, 8 complete blocks.
- Reset asserted with both buffer entries full -> next cycle out_valid=0, in_ready=0. After release, in_ready=1 and the first new beat carries out_row=0.

Source files
------------

// File: rtl/satd_pkg.sv
// Shared types and helpers for the SATD datapath: residual width, mode encoding
// and the row tag passed along with each beat to the Hadamard stage.
package satd_pkg;

  localparam int DEFAULT_BIT_DEPTH = 8;
  localparam int SATD_MAX_ROW_W    = 5;

  typedef enum logic {
    SATD_SIGNED = 1'b0,
    SATD_ABS    = 1'b1
  } satd_mode_t;

  // Row field sized for the largest block; narrower blocks zero-extend.
  typedef struct packed {
    logic [SATD_MAX_ROW_W-1:0] row;
    logic                      first;
    logic                      last;
  } satd_tag_t;

  function automatic int diff_w(input int bd);
    return bd + 1;
  endfunction

endpackage

// File: rtl/satd_skid_buf.sv
// Two-entry valid/ready buffer: a main output register plus one skid register.
// in_ready is a flop so downstream ready never reaches upstream combinationally.
module satd_skid_buf #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a beat moves on any cycle where its valid and ready are both high;
  // out_valid/out_data hold until that happens.
  logic         main_valid;
  logic [W-1:0] main_data;
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         ready_q;
  logic         accept;
  logic         main_free;
  logic         skid_next;

  assign accept    = in_valid && ready_q;
  assign main_free = !main_valid || out_ready;

  // The skid only fills while main is held, and always empties into a freed main.
  always_comb begin
    skid_next = 1'b0;
    if (!main_free) skid_next = skid_valid || accept;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (main_free) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_data  <= skid_data;
        end else begin
          main_valid <= accept;
          if (accept) main_data <= in_data;
        end
      end else if (accept) begin
        skid_data <= in_data;
      end
      skid_valid <= skid_next;
      ready_q    <= !skid_next;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/satd_diff_stage.sv
// Residual stage at the head of the SATD datapath: per-lane ORG-CUR (signed or
// absolute), tagged with the row position inside its block, through a skid buffer.
module satd_diff_stage
  import satd_pkg::*;
#(
  parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH,
  parameter int LANES     = 8,
  parameter int ROWS      = 8
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*BIT_DEPTH-1:0]       org,
  input  logic [LANES*BIT_DEPTH-1:0]       cur,
  input  logic                             abs_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*(BIT_DEPTH+1)-1:0]   diff,
  output logic [$clog2(ROWS)-1:0]          out_row,
  output logic                             out_first,
  output logic                             out_last
);

  localparam int DW = diff_w(BIT_DEPTH);
  localparam int RW = $clog2(ROWS);
  localparam int PW = LANES*DW + RW + 2;

  logic              accept;
  logic [RW-1:0]     row_q;
  satd_mode_t        mode_q;
  satd_mode_t        eff_mode;
  logic [DW-1:0]     o_x, c_x, d_x;
  logic [LANES*DW-1:0] diff_in;
  logic [PW-1:0]     pay_in;
  logic [PW-1:0]     pay_out;

  assign accept = in_valid && in_ready;

  // Row 0 uses the live abs_mode so the whole block shares the mode it started with.
  always_comb begin
    eff_mode = (row_q == '0) ? satd_mode_t'(abs_mode) : mode_q;
    diff_in  = '0;
    o_x      = '0;
    c_x      = '0;
    d_x      = '0;
    for (int i = 0; i < LANES; i++) begin
      o_x = {1'b0, org[i*BIT_DEPTH +: BIT_DEPTH]};
      c_x = {1'b0, cur[i*BIT_DEPTH +: BIT_DEPTH]};
      d_x = o_x - c_x;
      if (eff_mode == SATD_ABS && d_x[DW-1]) d_x = c_x - o_x;
      diff_in[i*DW +: DW] = d_x;
    end
  end

  assign pay_in = {diff_in, row_q, (row_q == '0), (row_q == RW'(ROWS-1))};

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_q  <= '0;
      mode_q <= SATD_SIGNED;
    end else if (accept) begin
      row_q <= row_q + RW'(1);
      if (row_q == '0) mode_q <= satd_mode_t'(abs_mode);
    end
  end

  satd_skid_buf #(.W(PW)) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {diff, out_row, out_first, out_last} = pay_out;

endmodule
